// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 32 x 64-bit architectural register file.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 64;
    localparam int IDX_W    = 5;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

    // Packed view presented to the read-select muxes; slot ZERO_REG is constant 0.
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] regs_t;
    // Backing storage: only X0..X30 exist as flops.
    typedef logic [NUM_REGS-2:0][DATA_W-1:0] store_t;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_decoder5_32.sv
// RegWrite-gated 5-to-32 one-hot write-enable decoder; the X31 enable is always 0.
module decoder5_32
    import regfile_pkg::*;
(
    input  logic                en_i,
    input  reg_idx_t            idx_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        // NOTE: default assigned first so every path drives every bit -- no latch.
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
        onehot_o[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile_mux64.sv
// 32:1 read-select mux of 64-bit words from the packed register array.
module mux64
    import regfile_pkg::*;
(
    input  regs_t    data_i,
    input  reg_idx_t sel_i,
    output word_t    data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/regfile.sv
// 32 x 64-bit register file: one synchronous write port, two combinational read ports, X31 = 0.
// Optional REGFILE_BYPASS_EN: write-first forwarding of WriteData to matching read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2
);

    store_t              regs_q;
    store_t              regs_d;
    regs_t               regs_packed;
    logic [NUM_REGS-1:0] we;
    word_t               mux_rd1;
    word_t               mux_rd2;
    logic                unused_we_zero;

    decoder5_32 u_dec (
        .en_i     (RegWrite),
        .idx_i    (WriteRegister),
        .onehot_o (we)
    );

    // The X31 enable is forced low inside the decoder and has no storage to drive.
    assign unused_we_zero = we[ZERO_REG];

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (we[i]) begin
                regs_d[i] = WriteData;
            end
        end
    end

    // NOTE: storage is real flops, so it can and does take the async clear; non-blocking for state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs_packed = {{DATA_W{1'b0}}, regs_q};

    mux64 u_rd1_mux (
        .data_i (regs_packed),
        .sel_i  (ReadRegister1),
        .data_o (mux_rd1)
    );

    mux64 u_rd2_mux (
        .data_i (regs_packed),
        .sel_i  (ReadRegister2),
        .data_o (mux_rd2)
    );

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed under reset so reads stay zero while storage is held clear.
    logic fwd1;
    logic fwd2;

    assign fwd1 = !reset && RegWrite && (WriteRegister == ReadRegister1) && !is_zero_reg(ReadRegister1);
    assign fwd2 = !reset && RegWrite && (WriteRegister == ReadRegister2) && !is_zero_reg(ReadRegister2);

    assign ReadData1 = fwd1 ? WriteData : mux_rd1;
    assign ReadData2 = fwd2 ? WriteData : mux_rd2;
`else
    assign ReadData1 = mux_rd1;
    assign ReadData2 = mux_rd2;
`endif

endmodule
